// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU round-robin arbiter.
package alu_pkg;

    localparam int OP_W        = 2;
    localparam int OPND_W      = 3;
    localparam int ALU_LAT_DEF = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        DONE  = S_DONE
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin winner select.
module rr_pick2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] pick_o
);

    // last_i names the requester served most recently; the other wins a tie
    always_comb begin
        pick_o = 2'b00;
        if (req0_i && req1_i) begin
            pick_o = last_i ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            pick_o = 2'b01;
        end else if (req1_i) begin
            pick_o = 2'b10;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one fixed-latency ALU core between two requesters with round-robin grant.
// Optional per-requester completion counters (gcnt0/gcnt1) when ALU_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate; latch winner's op/operands and grant
// ISSUE | pulse alu_en, load latency counter
// WAIT  | count down ALU latency, capture alu_res at zero
// DONE  | pulse winner's done, update last-served, drop grant
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int RES_W   = 6
) (
    input  logic              CLK_50,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [OP_W-1:0]   op0,
    input  logic [OPND_W-1:0] a0,
    input  logic [OPND_W-1:0] b0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op1,
    input  logic [OPND_W-1:0] a1,
    input  logic [OPND_W-1:0] b1,
    output logic [1:0]        gnt,
    output logic              done0,
    output logic              done1,
    output logic [RES_W-1:0]  res,
    output logic              busy,
    output logic [OP_W-1:0]   alu_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic              alu_en,
    input  logic [RES_W-1:0]  alu_res
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]        gcnt0,
    output logic [7:0]        gcnt1
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OPND_W-1:0] a_q, a_d;
    logic [OPND_W-1:0] b_q, b_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              last_q, last_d;
    logic [1:0]        pick;

    rr_pick2 u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .last_i (last_q),
        .pick_o (pick)
    );

    always_ff @(posedge CLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    gnt_d   = pick;
                    op_d    = pick[0] ? op0 : op1;
                    a_d     = pick[0] ? a0  : a1;
                    b_d     = pick[0] ? b0  : b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_res;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt    = gnt_q;
    assign res    = res_q;
    assign busy   = (state_q != IDLE);
    assign alu_en = (state_q == ISSUE);
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign done0  = (state_q == DONE) && gnt_q[0];
    assign done1  = (state_q == DONE) && gnt_q[1];

`ifdef ALU_ARB_STATS_EN
    logic [7:0] gcnt0_q, gcnt1_q;

    // saturating so a long soak never wraps back to a small count
    always_ff @(posedge CLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (done0 && (gcnt0_q != 8'hFF)) gcnt0_q <= gcnt0_q + 8'd1;
            if (done1 && (gcnt1_q != 8'hFF)) gcnt1_q <= gcnt1_q + 8'd1;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Round-robin arbiter and sequencer sharing one ALU core between two requesters (e.g. switch panel and auto-test sequencer).
- Grants one requester at a time.
- Latches its op/operands, issues a single alu_en strobe and waits the fixed ALU latency.
- Captures the result and returns it with a one-cycle done pulse.
- Sits between requester logic and the ALU core, upstream of the display decode.

Parameters:
ALU_LAT, 2, ALU core latency in cycles from alu_en strobe to valid alu_res (legal 1..15)
RES_W, 6, ALU result width (covers 3x3-bit product)

Ports:
CLK_50  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 request, level, held until done0
op0  in  2  requester 0 op code, sampled at grant
a0  in  3  requester 0 operand A, sampled at grant
b0  in  3  requester 0 operand B, sampled at grant
req1, op1, a1, b1  in  1/2/3/3  requester 1, same rules
gnt  out  2  one-hot grant, held from grant until done cycle inclusive
done0  out  1  one-cycle pulse, requester 0 result valid
done1  out  1  one-cycle pulse, requester 1 result valid
res  out  RES_W  captured result, stable from done until next capture
busy  out  1  high whenever state != IDLE
alu_op  out  2  to ALU core
alu_a  out  3  to ALU core
alu_b  out  3  to ALU core
alu_en  out  1  one-cycle issue strobe to ALU core
alu_res  in  RES_W  from ALU core, valid ALU_LAT cycles after alu_en

Behaviour:
Reset:
- gnt=0, done0=done1=0, res=0, busy=0, alu_en=0, alu_op/alu_a/alu_b=0.
- State IDLE; last-served pointer=1, so requester 0 wins the first tie.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, cycle t, any req high:
  - Choose winner: sole requester; if both, the one not last served.
  - Register gnt, alu_op/a/b from the winner's inputs.
  - Next state ISSUE.
- ISSUE (t+1): alu_en=1 for exactly this cycle; load wait counter with ALU_LAT-1; next WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter==0, capture alu_res into res; next DONE.
- DONE (t+2+ALU_LAT):
  - done of the granted requester = 1.
  - Update last-served pointer.
  - Clear gnt at end of cycle; next IDLE.
- Req-to-done latency = ALU_LAT+2 cycles. Minimum request spacing is ALU_LAT+3 cycles; back-to-back grants are possible because IDLE re-arbitrates on the cycle after DONE.

Boundary rules:
- alu_op/a/b hold latched values from grant through DONE; requester input changes after grant are ignored.
- req dropped mid-operation: operation completes, done still pulses, pointer still updates.
- req still high after done: treated as a new request; round-robin forces alternation if the other requester is waiting.
- Both req rising in the same cycle: tie rule above.
- Reset asserted mid-operation: immediate return to reset values; no done pulse; the in-flight result is discarded.
- ALU_LAT=1: WAIT lasts one cycle.

Optional Feature:
ALU_ARB_STATS_EN:
- Defined: adds outputs gcnt0 and gcnt1 (8 bits each), per-requester completed-operation counters.
  - Increment on each done pulse; saturate at 255.
  - Reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
Shared package alu_pkg:
- Op-code width 2 and operand width 3 constants.
- FSM state encoding localparams: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
- Default ALU_LAT.

Sub-module rr_pick2:
- Combinational 2-way round-robin winner select.
- Inputs: req0, req1, last-served pointer. Output: one-hot pick.
- Instantiated once.

Test Plan:
Bench ALU model: op 00 -> A+B, 01 -> A-B mod 2^RES_W, 10 -> A*B, 11 -> A&B; ALU_LAT=2.
1. Single request: req0=1, op0=00, a0=2, b0=5 at t -> alu_en at t+1, done0 at t+4, res=7, gnt=01 over t+1..t+4, busy low at t+5.
2. Simultaneous requests: req0 (op 10, 2,5) and req1 (op 00, 3,3) both rise after reset -> requester 0 served first (res=10, done0); requester 1 granted next (res=6, done1); no overlap of gnt bits.
3. Fairness: req0 and req1 held high for 6 operations -> grants alternate 0,1,0,1,0,1; exactly 3 done pulses each.
4. Operand stability: change a0 from 2 to 7 the cycle after grant -> alu_a stays 2; result uses 2.
5. Reset mid-operation: assert rst_n=0 during WAIT -> all outputs 0 immediately, no done; after release, req1 wins a tie only if requester 0 was served first.
6. ALU_ARB_STATS_EN defined: 300 requester-0 operations -> gcnt0 saturates at 255, gcnt1=0.
